// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush/bubble generation with a stall-cycle counter.
// Optional operand forwarding is enabled by defining HAZARD_FORWARD_EN.
module hazard_ctrl #(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int WB_DISTANCE  = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 hz_clk,
    input  logic                 hz_rst,
    input  logic                 hz_i_de_valid,
    input  logic [AWIDTH-1:0]    hz_i_de_addr_rs1,
    input  logic [AWIDTH-1:0]    hz_i_de_addr_rs2,
    input  logic                 hz_i_de_use_rs1,
    input  logic                 hz_i_de_use_rs2,
    input  logic                 hz_i_ex_valid,
    input  logic [AWIDTH-1:0]    hz_i_ex_addr_rd,
    input  logic                 hz_i_ex_we,
    input  logic                 hz_i_ex_is_load,
    input  logic                 hz_i_change_pc,
    input  logic                 hz_i_stall_alu,
    input  logic                 hz_i_mem_stall,
    output logic                 hz_o_stall_fe,
    output logic                 hz_o_stall_de,
    output logic                 hz_o_stall_ex,
    output logic                 hz_o_bubble_ex,
    output logic                 hz_o_flush_de,
    output logic                 hz_o_flush_ex,
    output logic                 hz_o_fwd_rs1,
    output logic                 hz_o_fwd_rs2,
    output logic [2:0]           hz_o_state,
    output logic [CNT_WIDTH-1:0] hz_o_stall_cnt
);

    // state    | meaning
    // RUN      | normal flow, evaluate all hazard sources
    // FLUSH    | decode flushed for remaining redirect cycles
    // MEM_WAIT | full pipeline held until memory is ready
    // ALU_WAIT | fetch/decode held until multi-cycle ALU op finishes
    // RAW_WAIT | bubbles inserted until producer result is written back
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        FLUSH    = 3'd1,
        MEM_WAIT = 3'd2,
        ALU_WAIT = 3'd3,
        RAW_WAIT = 3'd4
    } state_t;

    localparam int MAXC = (FLUSH_CYCLES > WB_DISTANCE) ? FLUSH_CYCLES : WB_DISTANCE;
    localparam int CW   = $clog2(MAXC + 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] perf_cnt;

    logic match1, match2, load_use, raw_stall;
    logic fwd1, fwd2;
    logic eval_run;
    logic stall_fe_c, stall_de_c, stall_ex_c, bubble_c, flush_de_c, flush_ex_c;

    assign match1 = hz_i_de_valid & hz_i_ex_valid & hz_i_ex_we & (hz_i_ex_addr_rd != '0) &
                    hz_i_de_use_rs1 & (hz_i_de_addr_rs1 == hz_i_ex_addr_rd);
    assign match2 = hz_i_de_valid & hz_i_ex_valid & hz_i_ex_we & (hz_i_ex_addr_rd != '0) &
                    hz_i_de_use_rs2 & (hz_i_de_addr_rs2 == hz_i_ex_addr_rd);
    assign load_use = (match1 | match2) & hz_i_ex_is_load;

`ifdef HAZARD_FORWARD_EN
    assign fwd1      = match1 & ~hz_i_ex_is_load;
    assign fwd2      = match2 & ~hz_i_ex_is_load;
    assign raw_stall = 1'b0;
`else
    assign fwd1      = 1'b0;
    assign fwd2      = 1'b0;
    assign raw_stall = (match1 | match2) & ~hz_i_ex_is_load;
`endif

    always_ff @(posedge hz_clk) begin
        if (hz_rst) begin
            state    <= RUN;
            cnt      <= '0;
            perf_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hz_o_stall_fe && (perf_cnt != '1))
                perf_cnt <= perf_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        eval_run   = 1'b0;
        stall_fe_c = 1'b0;
        stall_de_c = 1'b0;
        stall_ex_c = 1'b0;
        bubble_c   = 1'b0;
        flush_de_c = 1'b0;
        flush_ex_c = 1'b0;

        // Wait states re-evaluate as RUN each cycle, so a released stall
        // falls straight into whatever hazard is pending next.
        case (state)
            RUN, MEM_WAIT, ALU_WAIT: eval_run = 1'b1;
            FLUSH: begin
                if (hz_i_change_pc) begin
                    eval_run = 1'b1;
                end else begin
                    flush_de_c = 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            RAW_WAIT: begin
                if (hz_i_change_pc || hz_i_mem_stall || hz_i_stall_alu) begin
                    eval_run = 1'b1;
                end else begin
                    stall_fe_c = 1'b1;
                    stall_de_c = 1'b1;
                    bubble_c   = 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            default: state_nxt = RUN;
        endcase

        if (eval_run) begin
            state_nxt = RUN;
            if (hz_i_change_pc) begin
                flush_de_c = 1'b1;
                flush_ex_c = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CW'(FLUSH_CYCLES - 1);
                end
            end else if (hz_i_mem_stall) begin
                stall_fe_c = 1'b1;
                stall_de_c = 1'b1;
                stall_ex_c = 1'b1;
                state_nxt  = MEM_WAIT;
            end else if (hz_i_stall_alu) begin
                stall_fe_c = 1'b1;
                stall_de_c = 1'b1;
                state_nxt  = ALU_WAIT;
            end else if (load_use) begin
                stall_fe_c = 1'b1;
                stall_de_c = 1'b1;
                bubble_c   = 1'b1;
            end else if (raw_stall) begin
                stall_fe_c = 1'b1;
                stall_de_c = 1'b1;
                bubble_c   = 1'b1;
                if (WB_DISTANCE > 1) begin
                    state_nxt = RAW_WAIT;
                    cnt_nxt   = CW'(WB_DISTANCE - 1);
                end
            end
        end
    end

    assign hz_o_stall_fe  = stall_fe_c & ~hz_rst;
    assign hz_o_stall_de  = stall_de_c & ~hz_rst;
    assign hz_o_stall_ex  = stall_ex_c & ~hz_rst;
    assign hz_o_bubble_ex = bubble_c   & ~hz_rst;
    assign hz_o_flush_de  = flush_de_c & ~hz_rst;
    assign hz_o_flush_ex  = flush_ex_c & ~hz_rst;
    assign hz_o_fwd_rs1   = fwd1       & ~hz_rst;
    assign hz_o_fwd_rs2   = fwd2       & ~hz_rst;
    assign hz_o_state     = state;
    assign hz_o_stall_cnt = perf_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table from RUN plus multi-cycle sequences.
module tb_hazard_ctrl;

    logic       hz_clk;
    logic       hz_rst;
    logic       de_valid, use1, use2, ex_valid, we, is_load, cpc, alu, mem;
    logic [4:0] rs1, rs2, rd;
    logic       stall_fe, stall_de, stall_ex, bubble_ex, flush_de, flush_ex, fwd1, fwd2;
    logic [2:0] state;
    logic [3:0] stall_cnt;
    logic [7:0] ctl;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    hazard_ctrl #(.AWIDTH(5), .FLUSH_CYCLES(2), .WB_DISTANCE(2), .CNT_WIDTH(4)) dut (
        .hz_clk(hz_clk), .hz_rst(hz_rst),
        .hz_i_de_valid(de_valid), .hz_i_de_addr_rs1(rs1), .hz_i_de_addr_rs2(rs2),
        .hz_i_de_use_rs1(use1), .hz_i_de_use_rs2(use2),
        .hz_i_ex_valid(ex_valid), .hz_i_ex_addr_rd(rd), .hz_i_ex_we(we),
        .hz_i_ex_is_load(is_load), .hz_i_change_pc(cpc), .hz_i_stall_alu(alu),
        .hz_i_mem_stall(mem),
        .hz_o_stall_fe(stall_fe), .hz_o_stall_de(stall_de), .hz_o_stall_ex(stall_ex),
        .hz_o_bubble_ex(bubble_ex), .hz_o_flush_de(flush_de), .hz_o_flush_ex(flush_ex),
        .hz_o_fwd_rs1(fwd1), .hz_o_fwd_rs2(fwd2), .hz_o_state(state),
        .hz_o_stall_cnt(stall_cnt)
    );

    assign ctl = {stall_fe, stall_de, stall_ex, bubble_ex, flush_de, flush_ex, fwd1, fwd2};

    initial hz_clk = 1'b0;
    always #5 hz_clk = ~hz_clk;

    typedef struct packed {
        logic       de_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       ex_valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
        logic       cpc;
        logic       alu;
        logic       mem;
        logic [7:0] exp_ctl;
        logic [2:0] exp_state;
    } vec_t;

    function automatic vec_t mk(input logic dv, input logic [4:0] a1, input logic [4:0] a2,
                                input logic u1, input logic u2, input logic ev,
                                input logic [4:0] d, input logic w, input logic ld,
                                input logic c, input logic al, input logic m,
                                input logic [7:0] ec, input logic [2:0] es);
        vec_t v;
        v.de_valid = dv; v.rs1 = a1; v.rs2 = a2; v.use1 = u1; v.use2 = u2;
        v.ex_valid = ev; v.rd = d; v.we = w; v.is_load = ld;
        v.cpc = c; v.alu = al; v.mem = m; v.exp_ctl = ec; v.exp_state = es;
        return v;
    endfunction

    task automatic step;
        @(posedge hz_clk);
        #1;
    endtask

    task automatic idle_inputs;
        de_valid = 0; use1 = 0; use2 = 0; ex_valid = 0; we = 0; is_load = 0;
        cpc = 0; alu = 0; mem = 0; rs1 = '0; rs2 = '0; rd = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        hz_rst = 1'b1;
        step();
        hz_rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[13];

    initial begin
        // {stall_fe, stall_de, stall_ex, bubble, flush_de, flush_ex, fwd1, fwd2}
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 3'd0);
        vecs[1]  = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 8'b1101_0000, 3'd0);
        vecs[2]  = mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 8'b0000_0000, 3'd0);
        vecs[3]  = mk(1, 3, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,
                      FWD ? 8'b0000_0001 : 8'b1101_0000, FWD ? 3'd0 : 3'd4);
        vecs[4]  = mk(1, 9, 2, 1, 1, 1, 9, 1, 0, 0, 0, 0,
                      FWD ? 8'b0000_0010 : 8'b1101_0000, FWD ? 3'd0 : 3'd4);
        vecs[5]  = mk(1, 3, 7, 1, 0, 1, 7, 1, 0, 0, 0, 0, 8'b0000_0000, 3'd0);
        vecs[6]  = mk(1, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0, 0, 8'b0000_0000, 3'd0);
        vecs[7]  = mk(0, 0, 7, 0, 1, 1, 7, 1, 0, 0, 0, 0, 8'b0000_0000, 3'd0);
        vecs[8]  = mk(1, 0, 7, 0, 1, 0, 7, 1, 0, 0, 0, 0, 8'b0000_0000, 3'd0);
        vecs[9]  = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 0, 0, 8'b0000_1100, 3'd1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'b1110_0000, 3'd2);
        vecs[11] = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 1, 0, 8'b1100_0000, 3'd3);
        vecs[12] = mk(1, 5, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 8'b1101_0000, 3'd0);

        // reset forces outputs low even with a pending stall source
        idle_inputs();
        hz_rst = 1'b1;
        mem = 1'b1; alu = 1'b1; cpc = 1'b1;
        #2;
        chk("rst_ctl", {24'd0, ctl}, 32'd0);
        step();
        idle_inputs();
        hz_rst = 1'b0;
        #2;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            de_valid = vecs[i].de_valid; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            use1 = vecs[i].use1; use2 = vecs[i].use2; ex_valid = vecs[i].ex_valid;
            rd = vecs[i].rd; we = vecs[i].we; is_load = vecs[i].is_load;
            cpc = vecs[i].cpc; alu = vecs[i].alu; mem = vecs[i].mem;
            #2;
            chk($sformatf("vec%0d_ctl", i), {24'd0, ctl}, {24'd0, vecs[i].exp_ctl});
            step();
            chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, vecs[i].exp_state});
            chk($sformatf("vec%0d_cnt", i), {28'd0, stall_cnt}, {31'd0, vecs[i].exp_ctl[7]});
        end

        // load-use stalls exactly one cycle
        do_reset();
        de_valid = 1; use1 = 1; rs1 = 5; ex_valid = 1; rd = 5; we = 1; is_load = 1;
        #2;
        chk("lu_c1", {24'd0, ctl}, 32'hD0);
        step();
        idle_inputs();
        de_valid = 1; use1 = 1; rs1 = 5;
        #2;
        chk("lu_c2", {24'd0, ctl}, 32'h00);
        chk("lu_state", {29'd0, state}, 32'd0);
        chk("lu_cnt", {28'd0, stall_cnt}, 32'd1);

        // redirect pulse: flush_de two cycles, flush_ex first only
        do_reset();
        cpc = 1;
        #2;
        chk("rd_c1", {24'd0, ctl}, 32'h0C);
        step();
        cpc = 0;
        #2;
        chk("rd_c2_state", {29'd0, state}, 32'd1);
        chk("rd_c2", {24'd0, ctl}, 32'h08);
        step();
        #2;
        chk("rd_c3_state", {29'd0, state}, 32'd0);
        chk("rd_c3", {24'd0, ctl}, 32'h00);

        // mem stall for 4 cycles with redirect on the 3rd
        do_reset();
        mem = 1;
        #2;
        chk("ms_c1", {24'd0, ctl}, 32'hE0);
        step();
        chk("ms_c2_state", {29'd0, state}, 32'd2);
        chk("ms_c2", {24'd0, ctl}, 32'hE0);
        step();
        cpc = 1;
        #2;
        chk("ms_c3", {24'd0, ctl}, 32'h0C);
        step();
        cpc = 0;
        #2;
        chk("ms_c4_state", {29'd0, state}, 32'd1);
        chk("ms_c4", {24'd0, ctl}, 32'h08);
        step();
        mem = 0;
        #2;
        chk("ms_end_state", {29'd0, state}, 32'd0);
        chk("ms_cnt", {28'd0, stall_cnt}, 32'd2);

        // RAW on rs2 from a non-load producer
        do_reset();
        de_valid = 1; use2 = 1; rs2 = 7; ex_valid = 1; rd = 7; we = 1;
        #2;
`ifdef HAZARD_FORWARD_EN
        chk("raw_fwd", {24'd0, ctl}, 32'h01);
        step();
        chk("raw_fwd_state", {29'd0, state}, 32'd0);
        chk("raw_fwd_cnt", {28'd0, stall_cnt}, 32'd0);
`else
        chk("raw_c1", {24'd0, ctl}, 32'hD0);
        step();
        chk("raw_c2_state", {29'd0, state}, 32'd4);
        chk("raw_c2", {24'd0, ctl}, 32'hD0);
        step();
        idle_inputs();
        #2;
        chk("raw_c3_state", {29'd0, state}, 32'd0);
        chk("raw_c3", {24'd0, ctl}, 32'h00);
        chk("raw_cnt", {28'd0, stall_cnt}, 32'd2);
`endif

        // reset in the middle of an ALU wait
        do_reset();
        alu = 1;
        step();
        chk("alu_state", {29'd0, state}, 32'd3);
        chk("alu_ctl", {24'd0, ctl}, 32'hC0);
        step();
        hz_rst = 1;
        #2;
        chk("alu_rst_ctl", {24'd0, ctl}, 32'h00);
        step();
        hz_rst = 0;
        #2;
        chk("alu_rst_state", {29'd0, state}, 32'd0);
        chk("alu_rst_cnt", {28'd0, stall_cnt}, 32'd0);

        // perf counter saturates at all-ones
        do_reset();
        alu = 1;
        repeat (20) step();
        chk("sat_cnt", {28'd0, stall_cnt}, 32'd15);
        chk("sat_state", {29'd0, state}, 32'd3);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the fetch/decode/execute core.
- Watches decode-stage operand addresses, execute-stage destination/load info, branch redirect (change_pc), ALU multi-cycle stall and memory stall.
- Generates per-stage stall, flush and bubble controls that feed the connect/execute stall-flush-ce chain.
- Holds multi-cycle conditions in a small FSM and keeps a stall-cycle performance counter.

Parameters:
- AWIDTH, 5, register address width
- FLUSH_CYCLES, 2, cycles decode is flushed after a redirect (>=1)
- WB_DISTANCE, 2, stall cycles for a non-forwarded RAW hazard (>=1)
- CNT_WIDTH, 16, width of stall performance counter

Ports:
- hz_clk  in  1  clock, rising edge
- hz_rst  in  1  reset, synchronous, active-high
- hz_i_de_valid  in  1  decode holds valid instruction
- hz_i_de_addr_rs1  in  AWIDTH  decode rs1 address
- hz_i_de_addr_rs2  in  AWIDTH  decode rs2 address
- hz_i_de_use_rs1  in  1  decode instruction reads rs1
- hz_i_de_use_rs2  in  1  decode instruction reads rs2
- hz_i_ex_valid  in  1  execute holds valid instruction
- hz_i_ex_addr_rd  in  AWIDTH  execute destination
- hz_i_ex_we  in  1  execute writes rd
- hz_i_ex_is_load  in  1  execute instruction is a load
- hz_i_change_pc  in  1  execute redirect (taken branch/jump)
- hz_i_stall_alu  in  1  ALU multi-cycle busy
- hz_i_mem_stall  in  1  data memory not ready
- hz_o_stall_fe  out  1  hold fetch/PC
- hz_o_stall_de  out  1  hold decode register
- hz_o_stall_ex  out  1  hold execute register
- hz_o_bubble_ex  out  1  inject NOP into execute
- hz_o_flush_de  out  1  kill decode content
- hz_o_flush_ex  out  1  kill execute content
- hz_o_fwd_rs1  out  1  select execute result for rs1
- hz_o_fwd_rs2  out  1  select execute result for rs2
- hz_o_state  out  3  FSM state
- hz_o_stall_cnt  out  CNT_WIDTH  cycles with hz_o_stall_fe=1, saturating

Behaviour:
- Reset: hz_rst high at a rising edge gives state=RUN, cnt=0, hz_o_stall_cnt=0. While hz_rst is high, all control outputs are forced 0. Reset mid-stall aborts the stall immediately.
- Match definitions:
  - match1 = de_valid & ex_valid & ex_we & ex_addr_rd!=0 & use_rs1 & rs1==ex_addr_rd; match2 is the same for rs2.
  - load_use = (match1|match2) & ex_is_load.
  - raw = (match1|match2) & !ex_is_load.
- Outputs are combinational from state and inputs; state, cnt and perf counter are registered.
- Priority in every state: change_pc > mem_stall > stall_alu > load_use > raw.
- Encoding: RUN=0, FLUSH=1, MEM_WAIT=2, ALU_WAIT=3, RAW_WAIT=4.
- RUN:
  - change_pc: flush_de=1, flush_ex=1. Go to FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
  - mem_stall: stall_fe=stall_de=stall_ex=1. Go to MEM_WAIT.
  - stall_alu: stall_fe=stall_de=1. Go to ALU_WAIT.
  - load_use: stall_fe=stall_de=1, bubble_ex=1 for exactly 1 cycle. Stay in RUN.
  - raw (forwarding off only): stall_fe=stall_de=1, bubble_ex=1. Go to RAW_WAIT with cnt=WB_DISTANCE-1, or stay in RUN if WB_DISTANCE==1.
- FLUSH: flush_de=1, no stall. cnt decrements; go to RUN when cnt==0. A new change_pc reloads cnt and also asserts flush_ex.
- MEM_WAIT: holds the three stall outputs while mem_stall=1. When mem_stall=0, stalls drop in the same cycle and the next state is evaluated as RUN.
- ALU_WAIT: same as MEM_WAIT, keyed on stall_alu. A mem_stall arriving here moves to MEM_WAIT.
- RAW_WAIT: stall_fe=stall_de=1, bubble_ex=1. cnt decrements; go to RUN at cnt==0.
- change_pc in any wait state wins: flush both stages and go to FLUSH, abandoning the stall.
- Perf counter: +1 on each cycle with stall_fe=1, saturates at all-ones.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined:
  - hz_o_fwd_rs1 = match1 & !ex_is_load; hz_o_fwd_rs2 likewise.
  - raw never stalls; RAW_WAIT is unreachable.
- Undefined:
  - fwd outputs tied 0.
  - raw uses RAW_WAIT as above.

Test Plan:
- Load-use: ex load rd=5, we=1; decode use_rs1, rs1=5 -> stall_fe/stall_de/bubble_ex=1 for exactly 1 cycle, state stays 0, stall_cnt=1.
- rd=x0: ex rd=0, we=1, decode rs1=0 -> no stall, no forward.
- Redirect: change_pc pulse 1 cycle, FLUSH_CYCLES=2 -> flush_de=1 for 2 cycles, flush_ex=1 for the first cycle only, state 1 then 0.
- Mem stall with redirect: mem_stall=1 for 4 cycles, change_pc=1 on the 3rd -> stalls in cycles 1-2, flush wins in cycle 3, state=FLUSH.
- RAW: ALU op rd=7, decode rs2=7.
  - HAZARD_FORWARD_EN off, WB_DISTANCE=2: stall 2 cycles, state 4 then 0.
  - HAZARD_FORWARD_EN on: fwd_rs2=1, no stall.
- Reset mid-ALU_WAIT: stall_alu held, hz_rst=1 for 1 cycle -> outputs 0 that cycle, state=0, stall_cnt=0.
